// File: rtl/down_fifo_burst_ctrl_pkg.sv
// Shared definitions for the down-FIFO burst controller: state encoding,
// previous-word init value and the effective burst length rule.
package down_fifo_burst_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_e;

    localparam logic [31:0] PREV_WORD_INIT = 32'hFFFF_FFFF;
    localparam logic [15:0] DUP_CNT_MAX    = 16'hFFFF;

    // A programmed length of 0 stands for the maximum burst of 256 words.
    function automatic logic [8:0] eff_burst_len(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/down_fifo_dup_mon.sv
// Counts handshaked words equal to the word handshaked just before them.
module down_fifo_dup_mon
    import down_fifo_burst_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        hs_i,
    input  logic [31:0] dat_i,
    output logic [15:0] dup_cnt_o
);

    logic [31:0] prev_q, prev_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        if (hs_i) begin
            prev_d = dat_i;
            if ((dat_i == prev_q) && (cnt_q != DUP_CNT_MAX)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            prev_q <= PREV_WORD_INIT;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dup_cnt_o = cnt_q;

endmodule

// File: rtl/down_fifo_burst_ctrl.sv
// Drains a first-word-fall-through down FIFO in DMA bursts: full bursts when
// enough words are queued, partial bursts after an idle timeout.
module down_fifo_burst_ctrl
    import down_fifo_burst_ctrl_pkg::*;
#(
    parameter int CNT_W = 11
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             enable_i,
    input  logic [7:0]       burst_len_i,
    input  logic [15:0]      timeout_i,
    input  logic [31:0]      fifo_dat_i,
    input  logic             fifo_empty_i,
    input  logic [CNT_W-1:0] fifo_count_i,
    output logic             fifo_rd_o,
    output logic             burst_req_o,
    input  logic             burst_gnt_i,
    output logic [8:0]       burst_words_o,
    output logic [31:0]      dat_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             last_o,
    output logic             busy_o,
    output logic [15:0]      burst_cnt_o,
    output logic [15:0]      dup_cnt_o,
    output state_e           state_dbg_o
);

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [8:0]  words_q, words_d;
    logic [8:0]  rem_q, rem_d;
    logic [15:0] burst_cnt_q, burst_cnt_d;

    logic [8:0]  len_eff;
    logic [31:0] count_ext;
    logic        full_avail;
    logic        part_avail;
    logic        timer_hit;
    logic        start;
    logic        hs;

    assign len_eff    = eff_burst_len(burst_len_i);
    assign count_ext  = 32'(fifo_count_i);
    assign full_avail = count_ext >= 32'(len_eff);
    assign part_avail = (count_ext != 32'd0) && !full_avail;
    assign timer_hit  = (timeout_i != 16'd0) && (timer_q == timeout_i);
    assign start      = enable_i && (full_avail || ((count_ext != 32'd0) && timer_hit));

    // Gating with reset keeps a reset cycle from popping a word it will abandon.
    assign valid_o     = (state_q == ST_XFER) && !fifo_empty_i && reset_n_i;
    assign hs          = valid_o && ready_i;
    assign fifo_rd_o   = hs;
    assign last_o      = valid_o && (rem_q == 9'd1);
    assign dat_o       = (state_q == ST_XFER) ? fifo_dat_i : '0;
    assign burst_req_o = (state_q == ST_REQ);
    assign busy_o      = (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        words_d     = words_q;
        rem_d       = rem_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_REQ;
                    words_d = full_avail ? len_eff : 9'(count_ext);
                end else if (part_avail) begin
                    timer_d = (timer_q < timeout_i) ? timer_q + 16'd1 : timeout_i;
                end
            end
            ST_REQ: begin
                if (burst_gnt_i) begin
                    state_d = ST_XFER;
                    rem_d   = words_q;
                end
            end
            ST_XFER: begin
                if (hs) begin
                    rem_d = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        state_d     = ST_IDLE;
                        burst_cnt_d = burst_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            words_q     <= '0;
            rem_q       <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            words_q     <= words_d;
            rem_q       <= rem_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    down_fifo_dup_mon u_dup_mon (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .hs_i      (hs),
        .dat_i     (fifo_dat_i),
        .dup_cnt_o (dup_cnt_o)
    );

    assign burst_words_o = words_q;
    assign burst_cnt_o   = burst_cnt_q;
    assign state_dbg_o   = state_q;

endmodule
